// File: rtl/mcu_pkg.sv
// Shared MCU definitions: datapath widths and the writeback source encoding.
package mcu_pkg;

   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int REG_AW = $clog2(NREGS);

   // Writeback source selector; used both for the current grant and for the
   // round-robin history between the LSU and the MDU.
   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_ALU  = 2'd1,
      WB_LSU  = 2'd2,
      WB_MDU  = 2'd3
   } wb_src_e;

endpackage : mcu_pkg

// File: rtl/mcu_wb_scoreboard.sv
// Pending-destination scoreboard for long-latency ops (loads, mul/div).
// A bit is set when an op issues and cleared when its result is written back.
// If both hit the same register in one cycle, the new issue wins.
module mcu_wb_scoreboard
   import mcu_pkg::*;
#(
   parameter int NR = NREGS,
   parameter int AW = $clog2(NR)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          set_en_i,
   input  logic [AW-1:0] set_rd_i,
   input  logic          clr_en_i,
   input  logic [AW-1:0] clr_rd_i,
   output logic [NR-1:0] pend_mask_o
);

   logic [NR-1:0] pend_q;
   logic [NR-1:0] pend_d;

   // Next-state mask: clear first, then set, so a same-cycle set overrides.
   always_comb begin
      // NOTE: start from the held value so every path assigns pend_d; no latch.
      pend_d = pend_q;
      if (clr_en_i && (clr_rd_i != '0)) begin
         pend_d[clr_rd_i] = 1'b0;
      end
      if (set_en_i && (set_rd_i != '0)) begin
         pend_d[set_rd_i] = 1'b1;
      end
      pend_d[0] = 1'b0;   // x0 is hardwired zero, never outstanding
   end

   // Mask register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: this is a small flop vector, not a RAM, so resetting it is cheap and required.
      if (rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign pend_mask_o = pend_q;

endmodule : mcu_wb_scoreboard

// File: rtl/mcu_wb_arbiter.sv
// Writeback arbiter for the single register-file write port.
// ALU has absolute priority (it cannot stall); LSU and MDU share the
// remaining slots round-robin. A starvation counter raises stall_req so the
// pipeline can open a bubble for the blocked long-latency source.
module mcu_wb_arbiter
   import mcu_pkg::*;
#(
   parameter int XLEN_P       = XLEN,
   parameter int NREGS_P      = NREGS,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alu_valid,
   input  logic [$clog2(NREGS_P)-1:0] alu_rd,
   input  logic [XLEN_P-1:0]          alu_data,
   input  logic                       lsu_valid,
   input  logic [$clog2(NREGS_P)-1:0] lsu_rd,
   input  logic [XLEN_P-1:0]          lsu_data,
   output logic                       lsu_ready,
   input  logic                       mdu_valid,
   input  logic [$clog2(NREGS_P)-1:0] mdu_rd,
   input  logic [XLEN_P-1:0]          mdu_data,
   output logic                       mdu_ready,
   input  logic                       iss_valid,
   input  logic [$clog2(NREGS_P)-1:0] iss_rd,
   output logic                       rf_we,
   output logic [$clog2(NREGS_P)-1:0] rf_waddr,
   output logic [XLEN_P-1:0]          rf_wdata,
   output logic [NREGS_P-1:0]         pend_mask,
   output logic                       stall_req
);

   localparam int AW = $clog2(NREGS_P);
   localparam logic [3:0] STARVE_MAX = 4'd15;
   localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

   wb_src_e           grant;
   wb_src_e           rr_last_q, rr_last_d;
   logic [AW-1:0]     gnt_rd;
   logic [XLEN_P-1:0] gnt_data;
   logic              lm_grant;

   logic              rf_we_q, rf_we_d;
   logic [AW-1:0]     rf_waddr_q, rf_waddr_d;
   logic [XLEN_P-1:0] rf_wdata_q, rf_wdata_d;
   logic [3:0]        starve_q, starve_d;
   logic              stall_q, stall_d;

   // Grant selection and the muxed write beat for this cycle.
   always_comb begin
      grant    = WB_NONE;
      gnt_rd   = '0;
      gnt_data = '0;
      if (alu_valid) begin
         grant = WB_ALU;
      end else if (lsu_valid && mdu_valid) begin
         grant = (rr_last_q == WB_LSU) ? WB_MDU : WB_LSU;
      end else if (lsu_valid) begin
         grant = WB_LSU;
      end else if (mdu_valid) begin
         grant = WB_MDU;
      end

      unique case (grant)
         WB_ALU:  begin gnt_rd = alu_rd; gnt_data = alu_data; end
         WB_LSU:  begin gnt_rd = lsu_rd; gnt_data = lsu_data; end
         WB_MDU:  begin gnt_rd = mdu_rd; gnt_data = mdu_data; end
         default: begin gnt_rd = '0;     gnt_data = '0;       end
      endcase
   end

   assign lsu_ready = (grant == WB_LSU);
   assign mdu_ready = (grant == WB_MDU);
   assign lm_grant  = lsu_ready || mdu_ready;

   // Next-state for round-robin history, output register and starvation logic.
   always_comb begin
      rr_last_d  = rr_last_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      starve_d   = starve_q;

      if (lm_grant) begin
         rr_last_d = grant;
      end

      if (grant != WB_NONE) begin
         rf_we_d    = (gnt_rd != '0);   // x0 beats are consumed but not written
         rf_waddr_d = gnt_rd;
         rf_wdata_d = gnt_data;
      end

      if (lm_grant) begin
         starve_d = '0;
      end else if (alu_valid && (lsu_valid || mdu_valid) && (starve_q != STARVE_MAX)) begin
         starve_d = starve_q + 4'd1;
      end

      // Registered from the next count so stall_req tracks the counter
      // register cycle for cycle and drops the cycle after a grant.
      stall_d = (starve_d >= LIMIT);
   end

   // State registers with synchronous reset; in-flight writes are dropped.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      if (rst) begin
         rr_last_q  <= WB_MDU;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         starve_q   <= '0;
         stall_q    <= 1'b0;
      end else begin
         rr_last_q  <= rr_last_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         starve_q   <= starve_d;
         stall_q    <= stall_d;
      end
   end

   mcu_wb_scoreboard #(
      .NR (NREGS_P),
      .AW (AW)
   ) u_scoreboard (
      .clk         (clk),
      .rst         (rst),
      .set_en_i    (iss_valid),
      .set_rd_i    (iss_rd),
      .clr_en_i    (lm_grant),
      .clr_rd_i    (gnt_rd),
      .pend_mask_o (pend_mask)
   );

   assign rf_we     = rf_we_q;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wdata  = rf_wdata_q;
   assign stall_req = stall_q;

endmodule : mcu_wb_arbiter

// File: doc/mcu_wb_arbiter.md
Name: mcu_wb_arbiter

Overview:
- Writeback stage feeding the MCU integer register file's single write port (we/waddr/wdata).
- Merges three result sources: ALU (fixed latency, cannot stall), LSU load return (valid/ready), MDU mul/div (valid/ready).
- Keeps a pending-destination scoreboard for long-latency ops so decode can interlock.
- Raises a registered stall request when the ALU starves the other sources.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, architectural registers (register address width = $clog2(NREGS)).
- STARVE_LIMIT, 8, consecutive ALU-blocked cycles before stall_req asserts (range 1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- alu_valid  in  1  ALU result present; always accepted.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  load result present.
- lsu_rd  in  5  load destination register.
- lsu_data  in  XLEN  load data.
- lsu_ready  out  1  load result accepted this cycle.
- mdu_valid  in  1  MDU result present.
- mdu_rd  in  5  MDU destination register.
- mdu_data  in  XLEN  MDU result.
- mdu_ready  out  1  MDU result accepted this cycle.
- iss_valid  in  1  long-latency op (load/MDU) issued this cycle.
- iss_rd  in  5  destination of the issued op.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- pend_mask  out  NREGS  bit r set = writeback to xr outstanding.
- stall_req  out  1  request for the pipeline to insert one ALU bubble.

Behaviour:
- Reset: rf_we=0, rf_waddr=0, rf_wdata=0, pend_mask=0, stall_req=0, starve counter=0, rr_last=MDU (so the LSU wins first contention).
- Grant, combinational in cycle N:
  - alu_valid=1 → ALU wins; lsu_ready=0, mdu_ready=0.
  - Else if exactly one of lsu_valid/mdu_valid is set → that source is granted.
  - Else if both are set → grant the source not equal to rr_last.
  - Grant = valid & ready.
- rr_last updates to the granted source on every LSU/MDU grant.
- Ready may depend on valid. Sources must not make valid depend on ready. A source holding valid must keep rd/data stable until granted.
- Output register: the granted rd/data appear on rf_waddr/rf_wdata at cycle N+1 with rf_we=1. Latency is exactly one cycle.
- With no grant, rf_we=0 next cycle and rf_waddr/rf_wdata hold their values.
- x0 destination: the result is still accepted (ready asserted, consumes the beat). rf_we=0 in N+1.
- Scoreboard, updated at the clock edge:
  - Set: iss_valid & iss_rd≠0 → set pend_mask[iss_rd].
  - Clear: an LSU/MDU grant with rd≠0 → clear pend_mask[rd].
  - Set and clear on the same rd in the same cycle → set wins.
  - ALU grants never touch pend_mask.
  - pend_mask[0] is constant 0.
- Starvation:
  - Counter increments (saturating at 15) in every cycle where alu_valid=1 and (lsu_valid|mdu_valid)=1.
  - Counter clears on any LSU/MDU grant.
  - stall_req is registered: 1 in the cycle after counter ≥ STARVE_LIMIT, and deasserts the cycle after the counter clears.
  - The pipeline answers stall_req by presenting alu_valid=0 for at least one cycle. If the ALU is still valid, the ALU still wins; this is not an error here.
- Reset asserted mid-operation: all state returns to reset values next edge. In-flight accepted writes are dropped (rf_we=0).

Decomposition:
- Shared package mcu_pkg: XLEN, NREGS, REG_AW, and the wb_src_e enum (WB_NONE, WB_ALU, WB_LSU, WB_MDU) used for the grant and rr_last.
- One sub-module: mcu_wb_scoreboard, holding the pend_mask set/clear logic with set-priority and the x0 mask. Arbitration, output register and starve counter stay in the top module.

Test Plan:
- ALU only: alu_valid=1, rd=5, data=0xDEADBEEF in cycle 3 → rf_we=1, waddr=5, wdata=0xDEADBEEF in cycle 4; rf_we=0 in cycle 5.
- LSU+MDU contention: both valid, rd=7/9, no ALU, held → cycle N LSU granted (lsu_ready=1), N+1 MDU granted; writes to x7 then x9 on consecutive cycles.
- ALU blocks load: alu_valid=1 for 10 cycles with lsu_valid=1 (STARVE_LIMIT=8) → lsu_ready=0 throughout. Counter reaches 8 after 8 cycles and stall_req=1 the next cycle. Drop alu_valid → LSU granted, stall_req returns to 0 one cycle after the grant.
- Scoreboard: iss_valid with rd=12 → pend_mask[12]=1 next cycle. MDU grant for rd=12 → bit clears. Simultaneous issue rd=12 and grant rd=12 → bit stays 1.
- x0 write: mdu_valid, rd=0, data=0x1234 → mdu_ready=1, rf_we=0 next cycle; iss_rd=0 never sets pend_mask.
- Reset mid-flight: assert rst the cycle a load is granted → next cycle rf_we=0, pend_mask=0, stall_req=0; after release the first contention grants the LSU.
